// File: rtl/parity_frame_tx.sv
// ---------------------------------------------------------------------------
// parity_frame_tx
//
// Serial framing transmitter. Each accepted parallel word goes out on a single
// line as: start bit (0), DATA_W data bits LSB first, parity bit, stop bit (1).
// Every bit is held for BIT_CYCLES clocks. The parity bit is computed here by
// XOR reduction of the accepted word, optionally inverted for odd parity.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous reset, active-high
//   data_in     word to transmit, captured on accept
//   data_valid  data_in holds a valid word
//   data_ready  block can accept a word this cycle (low while rst is high)
//   tx_out      registered serial line, idles high
//   tx_busy     frame in progress (START through STOP)
//   tx_done     one-cycle pulse in the first idle cycle after the stop bit
// ---------------------------------------------------------------------------
module parity_frame_tx #(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]        r_state;
  logic [DATA_W-1:0] r_shift;
  logic              r_parity;
  logic [TW-1:0]     r_timer;
  logic [IW-1:0]     r_bit_idx;
  logic              r_tx_out;
  logic              r_tx_done;

  logic              w_accept;
  logic              w_bit_end;
  logic              w_parity_in;
  logic [DATA_W-1:0] w_shift_next;

  // Ready is gated by rst so a word presented during reset is never consumed.
  assign data_ready   = (r_state == S_IDLE) && !rst;
  assign w_accept     = data_valid && data_ready;
  assign w_bit_end    = (r_timer == TIMER_LAST);
  assign w_parity_in  = (^data_in) ^ (PARITY_ODD != 0);
  assign w_shift_next = r_shift >> 1;

  assign tx_out  = r_tx_out;
  assign tx_busy = (r_state != S_IDLE);
  assign tx_done = r_tx_done;

  // tx_out is registered, so every transition loads the line value of the
  // bit slot being entered; the line then changes exactly with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values of the others, which is what a flop actually does.
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_tx_out  <= 1'b1;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;

      // Bit timer free-runs 0..BIT_CYCLES-1 in every busy state.
      if (r_state == S_IDLE || w_bit_end) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + TW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= data_in;
            r_parity  <= w_parity_in;
            r_bit_idx <= '0;
            r_tx_out  <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx_out <= r_shift[0];
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_LAST) begin
              r_tx_out  <= r_parity;
              r_bit_idx <= '0;
              r_state   <= S_PARITY;
            end else begin
              // Bit 0 of the shift register is always the bit on the line.
              r_shift   <= w_shift_next;
              r_tx_out  <= w_shift_next[0];
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx_out <= 1'b1;
            r_state  <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_tx_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_tx_out <= 1'b1;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_tx
//
// Three instances of parity_frame_tx share one clock and reset:
//   u_even : defaults (even parity, BIT_CYCLES=1)
//   u_odd  : PARITY_ODD=1
//   u_slow : BIT_CYCLES=4
// Expected per-cycle line/busy/done values are built from the frame format
// and queued when a word is driven, then popped one per cycle.
// ---------------------------------------------------------------------------
module tb_parity_frame_tx;

  typedef struct packed {
    logic tx;
    logic busy;
    logic done;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in [3];
  logic [2:0] data_valid;
  logic [2:0] data_ready;
  logic [2:0] tx_out;
  logic [2:0] tx_busy;
  logic [2:0] tx_done;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .data_in(data_in[0]), .data_valid(data_valid[0]),
    .data_ready(data_ready[0]), .tx_out(tx_out[0]), .tx_busy(tx_busy[0]),
    .tx_done(tx_done[0])
  );

  parity_frame_tx #(.DATA_W(4), .BIT_CYCLES(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .data_in(data_in[1]), .data_valid(data_valid[1]),
    .data_ready(data_ready[1]), .tx_out(tx_out[1]), .tx_busy(tx_busy[1]),
    .tx_done(tx_done[1])
  );

  parity_frame_tx #(.DATA_W(4), .BIT_CYCLES(4), .PARITY_ODD(0)) u_slow (
    .clk(clk), .rst(rst), .data_in(data_in[2]), .data_valid(data_valid[2]),
    .data_ready(data_ready[2]), .tx_out(tx_out[2]), .tx_busy(tx_busy[2]),
    .tx_done(tx_done[2])
  );

  function automatic obs_t observe(input int k);
    observe = '{tx: tx_out[k], busy: tx_busy[k], done: tx_done[k]};
  endfunction

  // Expected frame: start 0, d[0..3], parity, stop 1, each bc cycles, then
  // the tx_done idle cycle and optionally one more plain idle cycle.
  task automatic push_frame(input logic [3:0] d, input int bc, input logic odd,
                            input bit add_idle);
    logic [6:0] slots;
    slots[0] = 1'b0;
    for (int i = 0; i < 4; i++) slots[1+i] = d[i];
    slots[5] = (d[0] ^ d[1] ^ d[2] ^ d[3]) ^ odd;
    slots[6] = 1'b1;
    for (int s = 0; s < 7; s++)
      for (int c = 0; c < bc; c++)
        exp_q.push_back('{tx: slots[s], busy: 1'b1, done: 1'b0});
    exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b1});
    if (add_idle) exp_q.push_back('{tx: 1'b1, busy: 1'b0, done: 1'b0});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_valid = '0;
    for (int k = 0; k < 3; k++) data_in[k] = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (observe(k) !== obs_t'(3'b100) || data_ready[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: tx/busy/done/ready got %b%b required 1000",
                 k, observe(k), data_ready[k]);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (data_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset dut%0d: got %b required 1", k, data_ready[k]);
      end
    end
  endtask

  task automatic test_basic_frame();
    int cyc = 0;
    obs_t e, g;
    data_in[0] = 4'b1011;
    data_valid[0] = 1'b1;
    push_frame(4'b1011, 1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      data_valid[0] = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL basic_1011 cycle %0d: tx/busy/done got %b required %b", cyc, g, e);
      end
    end
  endtask

  task automatic test_parity_modes();
    logic [3:0] words [3];
    int         duts  [3];
    obs_t e, g;
    words[0] = 4'b0000; duts[0] = 0;
    words[1] = 4'b0000; duts[1] = 1;
    words[2] = 4'b1011; duts[2] = 1;
    for (int t = 0; t < 3; t++) begin
      int cyc = 0;
      int k = duts[t];
      data_in[k] = words[t];
      data_valid[k] = 1'b1;
      push_frame(words[t], 1, (k == 1), 1'b1);
      while (exp_q.size() != 0) begin
        @(negedge clk);
        data_valid[k] = 1'b0;
        cyc++;
        e = exp_q.pop_front();
        g = observe(k);
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL parity dut%0d word %b cycle %0d: tx/busy/done got %b required %b",
                   k, words[t], cyc, g, e);
        end
      end
    end
  endtask

  task automatic test_bit_cycles();
    int cyc = 0;
    obs_t e, g;
    data_in[2] = 4'b0110;
    data_valid[2] = 1'b1;
    push_frame(4'b0110, 4, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      data_valid[2] = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      g = observe(2);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL bit_cycles4 cycle %0d: tx/busy/done got %b required %b", cyc, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    obs_t e, g;
    data_in[0] = 4'hA;
    data_valid[0] = 1'b1;
    push_frame(4'hA, 1, 1'b0, 1'b0);
    push_frame(4'h5, 1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      cyc++;
      // Next word shows up mid-frame; valid stays high until the second
      // frame has started.
      if (cyc == 1) data_in[0] = 4'h5;
      if (cyc == 9) data_valid[0] = 1'b0;
      e = exp_q.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: tx/busy/done got %b required %b", cyc, g, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cyc = 0;
    obs_t e, g;
    data_in[0] = 4'b1111;
    data_valid[0] = 1'b1;
    push_frame(4'b1111, 1, 1'b0, 1'b0);
    // Observe start, bit 0, bit 1, bit 2; reset lands during bit 2.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_valid[0] = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL pre_reset cycle %0d: tx/busy/done got %b required %b", cyc, g, e);
      end
    end
    exp_q.delete();
    rst = 1'b1;
    #1;
    checks++;
    if (data_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_rst: got %b required 0", data_ready[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (observe(0) !== obs_t'(3'b100) || data_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL after_mid_reset: tx/busy/done/ready got %b%b required 1001",
               observe(0), data_ready[0]);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (observe(0) !== obs_t'(3'b100)) begin
        errors++;
        $display("FAIL no_done_after_reset cycle %0d: tx/busy/done got %b required 100",
                 i, observe(0));
      end
    end
    cyc = 0;
    data_in[0] = 4'b0001;
    data_valid[0] = 1'b1;
    push_frame(4'b0001, 1, 1'b0, 1'b1);
    while (exp_q.size() != 0) begin
      @(negedge clk);
      data_valid[0] = 1'b0;
      cyc++;
      e = exp_q.pop_front();
      g = observe(0);
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL post_reset_0001 cycle %0d: tx/busy/done got %b required %b", cyc, g, e);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1;
    data_in[0] = 4'b0101;
    data_valid[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    data_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      checks++;
      if (observe(0) !== obs_t'(3'b100)) begin
        errors++;
        $display("FAIL rst_priority cycle %0d: tx/busy/done got %b required 100",
                 i, observe(0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_modes();
    test_bit_cycles();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
Serial framing transmitter that consumes parallel data words and emits them on a single line with a computed parity bit.
Frame format: start bit (0), DATA_W data bits LSB first, parity bit, stop bit (1).
Sits directly downstream of the nibble parity generator stage in the combinational_ckt family. It recomputes the parity internally by XOR reduction, so it is self-contained.
Intended as the TX half of a simple parity-protected serial link.

Parameters:
DATA_W, 4, width of each data word in bits (>=1)
BIT_CYCLES, 1, clock cycles each serial bit is held on tx_out (>=1)
PARITY_ODD, 0, 0 = even parity (XOR of data bits), 1 = odd parity (inverted XOR)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  DATA_W  word to transmit, sampled on accept
data_valid  input  1  data_in is valid
data_ready  output  1  block can accept a word this cycle
tx_out  output  1  serial line, idles high
tx_busy  output  1  frame in progress (START through STOP)
tx_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst. All state changes occur on the rising edge of clk.
- Reset values: state=IDLE, tx_out=1, tx_busy=0, tx_done=0, counters=0. data_ready=0 while rst is high.
- States:
  - IDLE: tx_out=1, data_ready=1, tx_busy=0.
  - START, DATA, PARITY, STOP: tx_busy=1, data_ready=0.
- Accept: occurs when data_valid and data_ready are both high at a clock edge.
  - On accept, latch data_in into the shift register and latch the parity bit (^data_in, XOR PARITY_ODD). Then go to START.
  - data_in changes after accept have no effect on the frame in flight.
- tx_out is registered. Starting the cycle after accept, the line drives:
  - START: 0
  - DATA: bit 0 through bit DATA_W-1, LSB first
  - PARITY: the latched parity bit
  - STOP: 1
- Each bit is held for exactly BIT_CYCLES cycles, using a bit-timer that counts 0..BIT_CYCLES-1. Timer width is $clog2(BIT_CYCLES), minimum 1.
- DATA uses a bit index counter 0..DATA_W-1. DATA exits to PARITY when the index is DATA_W-1 and the timer expires.
- Frame length is (DATA_W+3)*BIT_CYCLES cycles.
- After STOP expires, return to IDLE.
  - tx_done=1 for exactly the first IDLE cycle.
  - data_ready is also 1 in that cycle, so back-to-back accept is allowed.
  - Back-to-back frames therefore have exactly one tx_out=1 idle cycle between the stop bit and the next start bit.
- data_valid while busy: ignored; the word is not consumed. The source must hold it until data_ready is high.
- Reset mid-frame takes effect at the next edge:
  - tx_out=1, state=IDLE.
  - tx_done is not pulsed and the in-flight word is discarded.
- rst takes priority over accept in the same cycle: no word is consumed.
- Fixed latency: accept edge to tx_done pulse is (DATA_W+3)*BIT_CYCLES+1 cycles.

Test Plan:
1. Defaults, data_in=4'b1011, one-cycle valid.
   - tx_out over cycles 1-7 after accept = 0,1,1,0,1,1,1 (parity=1).
   - tx_done=1 in cycle 8; tx_busy=1 in cycles 1-7 only.
2. data_in=4'b0000 (even), then the same word with PARITY_ODD=1.
   - tx_out = 0,0,0,0,0,0,1 for even parity.
   - Parity slot = 1 for odd parity; 4'b1011 with odd parity gives a parity slot of 0.
3. BIT_CYCLES=4, data_in=4'b0110.
   - Each bit is held 4 cycles: start cycles 1-4 low, ..., stop cycles 25-28 high.
   - tx_done in cycle 29.
4. data_valid held high with words 4'hA then 4'h5.
   - 4'hA is accepted. Changes to data_in during the frame do not alter the serialized bits.
   - 4'h5 is accepted in the tx_done cycle; the next start bit follows exactly one idle-high cycle after the stop bit.
5. Reset during DATA bit 2 of frame 4'b1111.
   - Next cycle: tx_out=1, tx_busy=0, data_ready=1 (after rst deasserts), no tx_done.
   - A new word 4'b0001 then transmits correctly.
6. rst and data_valid asserted in the same cycle.
   - Word not accepted; tx_out stays 1 and tx_busy stays 0.
